hazard_ctrl: RTL and testbench

//  Hazard and stall controller for the 5-stage RISC-V pipeline (F/D/E/M/W).

---
 rtl/hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for a 5-stage RISC-V pipeline (F/D/E/M/W).
// Produces stage stall/flush enables, E-stage forwarding selects, and
// sequences data-memory wait states with a timeout that halts the core.
// Optional feature macro: HAZARD_PERF_EN (adds saturating stall/flush
// performance counters PerfStallCnt / PerfFlushCnt of width CNT_W).
//
//  state   | meaning
//  --------+--------------------------------------------------------
//  S_IDLE  | no memory access outstanding, or zero-wait access
//  S_WAIT  | access in M waiting on MemReadyM, WaitCnt counting
//  S_FAULT | memory timeout; core halted until reset
module hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic [1:0] ResultSrcE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       PCSrcE,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       StallW,
    output logic       FlushD,
    output logic       FlushE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       MemFault
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] PerfStallCnt,
    output logic [CNT_W-1:0] PerfFlushCnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       lw_stall;
    logic       mem_stall;

    // Forwarding selects and stall/flush priority (memory > load-use > branch)
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        StallW    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;

        lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
        mem_stall = (MemReqM && !MemReadyM && (state != S_FAULT)) ||
                    (state == S_FAULT);

        if (!reset && (state != S_FAULT)) begin
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
                ForwardAE = 2'b10;
            else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
                ForwardAE = 2'b01;

            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
                ForwardBE = 2'b10;
            else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
                ForwardBE = 2'b01;
        end

        if (!reset) begin
            if (mem_stall) begin
                // Branch and load-use are re-evaluated once the stall releases
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                StallW = 1'b1;
            end else if (lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
                FlushD = PCSrcE;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    // Memory wait-state FSM; wait_cnt counts completed stall cycles of the access
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
            MemFault <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (MemReqM && !MemReadyM) begin
                        state    <= S_WAIT;
                        wait_cnt <= 8'd1;
                    end else begin
                        wait_cnt <= 8'd0;
                    end
                end
                S_WAIT: begin
                    if (!MemReqM || MemReadyM) begin
                        state    <= S_IDLE;
                        wait_cnt <= 8'd0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state    <= S_FAULT;
                        MemFault <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_FAULT: begin
                    MemFault <= 1'b1;
                end
                default: begin
                    state    <= S_IDLE;
                    wait_cnt <= 8'd0;
                    MemFault <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating stall/flush cycle counters, frozen once the core has faulted
    always_ff @(posedge clk) begin
        if (reset) begin
            PerfStallCnt <= '0;
            PerfFlushCnt <= '0;
        end else if (state != S_FAULT) begin
            if ((StallF || StallD || StallE || StallM || StallW) && (PerfStallCnt != '1))
                PerfStallCnt <= PerfStallCnt + 1'b1;
            if ((FlushD || FlushE) && (PerfFlushCnt != '1))
                PerfFlushCnt <= PerfFlushCnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (TIMEOUT_CYCLES = 4).
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic       StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       MemFault;
    logic [6:0] ctl;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LW   = 7'b1100001;
    localparam logic [6:0] C_LWBR = 7'b1100011;
    localparam logic [6:0] C_BR   = 7'b0000011;
    localparam logic [6:0] C_MEM  = 7'b1111100;

    assign ctl = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE};

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .StallW(StallW), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemFault(MemFault)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 2'b00; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    // advance one clock; inputs are then changed and checked mid-cycle
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        quiet();
        reset = 1'b1;
        cyc();
        // reset with every hazard condition present
        ResultSrcE = 2'b01; RdE = 3; Rs2D = 3; PCSrcE = 1; MemReqM = 1;
        RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1; Rs1E = 5; Rs2E = 5;
        #1;
        chk("rst_ctl", {1'b0, ctl}, 8'(C_NONE));
        chk("rst_fwdA", 8'(ForwardAE), 8'd0);
        chk("rst_fwdB", 8'(ForwardBE), 8'd0);
        chk("rst_fault", 8'(MemFault), 8'd0);
        cyc();
        quiet();
        reset = 1'b0;
        cyc();

        // forwarding: M beats W, zero register never forwarded
        RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1; Rs1E = 5; Rs2E = 7; #1;
        chk("fwdA_M", 8'(ForwardAE), 8'd2);
        chk("fwdB_none", 8'(ForwardBE), 8'd0);
        RdM = 0; #1;
        chk("fwdA_W", 8'(ForwardAE), 8'd1);
        RdW = 0; #1;
        chk("fwdA_none", 8'(ForwardAE), 8'd0);
        Rs2E = 9; RdW = 9; RdM = 9; RegWriteM = 0; #1;
        chk("fwdB_W", 8'(ForwardBE), 8'd1);
        RegWriteM = 1; #1;
        chk("fwdB_M", 8'(ForwardBE), 8'd2);
        chk("fwd_ctl", {1'b0, ctl}, 8'(C_NONE));
        quiet();
        cyc();

        // load-use stall, one cycle
        ResultSrcE = 2'b01; RdE = 3; Rs2D = 3; #1;
        chk("lw_stall", {1'b0, ctl}, 8'(C_LW));
        cyc();
        quiet(); #1;
        chk("lw_release", {1'b0, ctl}, 8'(C_NONE));
        ResultSrcE = 2'b01; RdE = 0; Rs1D = 0; Rs2D = 0; #1;
        chk("lw_rd0", {1'b0, ctl}, 8'(C_NONE));
        ResultSrcE = 2'b10; RdE = 3; Rs1D = 3; #1;
        chk("lw_notload", {1'b0, ctl}, 8'(C_NONE));
        ResultSrcE = 2'b01; PCSrcE = 1; #1;
        chk("lw_branch", {1'b0, ctl}, 8'(C_LWBR));
        ResultSrcE = 2'b00; #1;
        chk("branch", {1'b0, ctl}, 8'(C_BR));
        quiet();
        cyc();

        // three wait cycles, branch and load-use masked while stalled
        for (int i = 0; i < 3; i++) begin
            MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
            ResultSrcE = 2'b01; RdE = 4; Rs1D = 4; #1;
            chk($sformatf("memwait_%0d", i), {1'b0, ctl}, 8'(C_MEM));
            cyc();
        end
        quiet(); MemReqM = 1; MemReadyM = 1; #1;
        chk("mem_ready", {1'b0, ctl}, 8'(C_NONE));
        cyc();
        quiet(); #1;
        chk("mem_idle", {1'b0, ctl}, 8'(C_NONE));
        chk("mem_nofault", 8'(MemFault), 8'd0);
        // zero-wait access
        MemReqM = 1; MemReadyM = 1; #1;
        chk("zero_wait", {1'b0, ctl}, 8'(C_NONE));
        cyc();
        // second 3-cycle wait must not fault: count restarted on release
        for (int i = 0; i < 3; i++) begin
            MemReqM = 1; MemReadyM = 0; cyc();
        end
        MemReadyM = 1; cyc();
        quiet(); #1;
        chk("rewait_nofault", 8'(MemFault), 8'd0);

        // dropped request mid-wait returns to idle and clears the count
        MemReqM = 1; cyc(); cyc();
        MemReqM = 0; #1;
        chk("drop_req", {1'b0, ctl}, 8'(C_NONE));
        cyc();
        for (int i = 0; i < 3; i++) begin
            MemReqM = 1; MemReadyM = 0; cyc();
        end
        MemReadyM = 1; cyc();
        quiet(); #1;
        chk("drop_nofault", 8'(MemFault), 8'd0);

        // timeout after 4 stall cycles
        for (int i = 0; i < 4; i++) begin
            MemReqM = 1; MemReadyM = 0; #1;
            chk($sformatf("to_stall_%0d", i), {1'b0, ctl}, 8'(C_MEM));
            chk($sformatf("to_pre_%0d", i), 8'(MemFault), 8'd0);
            cyc();
        end
        quiet();
        RdM = 5; RegWriteM = 1; Rs1E = 5; Rs2E = 5; PCSrcE = 1; #1;
        chk("fault_set", 8'(MemFault), 8'd1);
        chk("fault_ctl", {1'b0, ctl}, 8'(C_MEM));
        chk("fault_fwdA", 8'(ForwardAE), 8'd0);
        chk("fault_fwdB", 8'(ForwardBE), 8'd0);
        MemReqM = 1; MemReadyM = 1;
        cyc(); cyc(); #1;
        chk("fault_held", 8'(MemFault), 8'd1);
        chk("fault_held_ctl", {1'b0, ctl}, 8'(C_MEM));
        reset = 1'b1; #1;
        chk("fault_rst_ctl", {1'b0, ctl}, 8'(C_NONE));
        cyc();
        reset = 1'b0; quiet(); #1;
        chk("fault_cleared", 8'(MemFault), 8'd0);
        chk("fault_cleared_ctl", {1'b0, ctl}, 8'(C_NONE));
        cyc();

        // reset in the middle of a wait (two stall cycles done)
        MemReqM = 1; MemReadyM = 0; cyc(); cyc();
        reset = 1'b1; RdW = 6; RegWriteW = 1; Rs1E = 6; #1;
        chk("midrst_ctl", {1'b0, ctl}, 8'(C_NONE));
        chk("midrst_fwdA", 8'(ForwardAE), 8'd0);
        cyc();
        reset = 1'b0; quiet(); #1;
        chk("midrst_idle", {1'b0, ctl}, 8'(C_NONE));
        chk("midrst_fault", 8'(MemFault), 8'd0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            MemReqM = 1; MemReadyM = 0; #1;
            chk($sformatf("midrst_pre_%0d", i), 8'(MemFault), 8'd0);
            cyc();
        end
        #1;
        chk("midrst_timeout", 8'(MemFault), 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
